// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: one shared BCD decoder, active-low anodes,
// per-slot dead time, leading-zero and invalid-nibble blanking, frame-coherent shadow capture.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    function automatic logic [3:0] nibble_sel(input logic [15:0] d, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = d[3:0];
            2'd1:    n = d[7:4];
            2'd2:    n = d[11:8];
            2'd3:    n = d[15:12];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // A digit is dark when its nibble is not BCD, or when it is part of the run of
    // leading zeros; digit 0 always shows so that an all-zero value reads "0".
    function automatic logic digit_suppressed(input logic [15:0] d, input logic [1:0] i,
                                              input logic lz);
        logic zero_run;
        case (i)
            2'd1:    zero_run = (d[15:4]  == 12'd0);
            2'd2:    zero_run = (d[15:8]  == 8'd0);
            2'd3:    zero_run = (d[15:12] == 4'd0);
            default: zero_run = 1'b0;
        endcase
        return (nibble_sel(d, i) > 4'd9) || (lz && zero_run);
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [15:0]   sh_digits_r;
    logic [3:0]    sh_dp_r;

    logic [CW-1:0] cnt_nx_s;
    logic [1:0]    idx_nx_s;
    logic          load_s;
    logic [15:0]   sh_digits_nx_s;
    logic [3:0]    sh_dp_nx_s;
    logic          lit_s;
    logic [3:0]    bcd_nx_s;
    logic [3:0]    an_nx_s;
    logic          dp_nx_s;

    // Next scan position and shadow contents; outputs are derived from this next state.
    always_comb begin
        cnt_nx_s = cnt_r;
        idx_nx_s = idx_r;
        load_s   = 1'b0;
        if (enable) begin
            if (cnt_r == LAST_CNT) begin
                cnt_nx_s = '0;
                idx_nx_s = idx_r + 2'd1;
                load_s   = (idx_r == 2'd3);
            end else begin
                cnt_nx_s = cnt_r + ONE_CNT;
            end
        end else begin
            cnt_nx_s = cnt_r;
        end
        sh_digits_nx_s = load_s ? digits : sh_digits_r;
        sh_dp_nx_s     = load_s ? dp_en  : sh_dp_r;
    end

    // Output decode; bcd_out follows the slot through the dead time so the decoder settles.
    always_comb begin
        lit_s   = enable && (cnt_nx_s >= BLANK_CNT)
                  && !digit_suppressed(sh_digits_nx_s, idx_nx_s, blank_lz);
        an_nx_s = 4'b1111;
        dp_nx_s = 1'b1;
        if (lit_s) begin
            an_nx_s[idx_nx_s] = 1'b0;
            dp_nx_s           = ~sh_dp_nx_s[idx_nx_s];
        end else begin
            an_nx_s = 4'b1111;
        end
        if (enable) begin
            bcd_nx_s = nibble_sel(sh_digits_nx_s, idx_nx_s);
        end else begin
            bcd_nx_s = bcd_out;
        end
    end

    // State and registered outputs; reset parks the scan one edge before a frame load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= LAST_CNT;
            idx_r       <= 2'd3;
            sh_digits_r <= 16'd0;
            sh_dp_r     <= 4'd0;
            bcd_out     <= 4'd0;
            an          <= 4'b1111;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt_r       <= cnt_nx_s;
            idx_r       <= idx_nx_s;
            sh_digits_r <= sh_digits_nx_s;
            sh_dp_r     <= sh_dp_nx_s;
            bcd_out     <= bcd_nx_s;
            an          <= an_nx_s;
            dp_n        <= dp_nx_s;
            frame_start <= load_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (REFRESH_DIV=8, BLANK_CYCLES=2): whole frames are
// checked cycle by cycle against hand-written per-digit expectations.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int frame_no = 0;

    seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp_en(dp_en),
        .blank_lz(blank_lz), .bcd_out(bcd_out), .an(an), .dp_n(dp_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Packed view {frame_start, dp_n, an, bcd_out}.
    function automatic logic [15:0] outs();
        return {6'd0, frame_start, dp_n, an, bcd_out};
    endfunction

    // Checks one 32-cycle frame starting at its first cycle. Next digits/dp are applied at
    // cycle 10 (must not show until the next frame); blank_lz is applied on the last cycle.
    // pause_at >= 0 drops enable for 5 cycles after that cycle.
    task automatic check_frame(input logic [15:0] e_bcd, input logic [3:0] e_lit,
                               input logic [3:0] e_dp, input int pause_at,
                               input logic [15:0] nxt_digits, input logic [3:0] nxt_dp,
                               input logic nxt_lz);
        int d;
        int c;
        logic on;
        logic [3:0] ea;
        logic [3:0] eb;
        logic ed;
        frame_no++;
        for (int j = 0; j < 32; j++) begin
            d  = j / 8;
            c  = j % 8;
            on = (c >= 2) && e_lit[d];
            ea = on ? ~(4'b0001 << d) : 4'b1111;
            eb = e_bcd[d*4 +: 4];
            ed = on ? ~e_dp[d] : 1'b1;
            chk($sformatf("f%0d c%0d", frame_no, j), outs(),
                {6'd0, (j == 0), ed, ea, eb});
            if (j == pause_at) begin
                enable = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk($sformatf("f%0d hold%0d", frame_no, k), outs(),
                        {6'd0, 1'b0, 1'b1, 4'b1111, eb});
                end
                enable = 1'b1;
            end
            if (j == 10) begin
                digits = nxt_digits;
                dp_en  = nxt_dp;
            end
            if (j == 31) blank_lz = nxt_lz;
            tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        digits   = 16'h1234;
        dp_en    = 4'b0010;
        blank_lz = 1'b0;
        repeat (3) tick();
        chk("reset", outs(), {6'd0, 1'b0, 1'b1, 4'b1111, 4'h0});

        // One released-but-idle cycle: still the reset picture.
        rst_n = 1'b1;
        tick();
        chk("idle", outs(), {6'd0, 1'b0, 1'b1, 4'b1111, 4'h0});
        enable = 1'b1;
        tick();
        chk("first_fs", {15'd0, frame_start}, 16'd1);
        chk("first_bcd", {12'd0, bcd_out}, 16'h0004);

        check_frame(16'h1234, 4'b1111, 4'b0010, -1, 16'h1234, 4'b0010, 1'b0);
        check_frame(16'h1234, 4'b1111, 4'b0010, -1, 16'h5678, 4'b0000, 1'b0);
        check_frame(16'h5678, 4'b1111, 4'b0000, -1, 16'h0045, 4'b0000, 1'b1);
        check_frame(16'h0045, 4'b0011, 4'b0000, -1, 16'h0000, 4'b0000, 1'b1);
        check_frame(16'h0000, 4'b0001, 4'b0000, -1, 16'h0405, 4'b0000, 1'b1);
        check_frame(16'h0405, 4'b0111, 4'b0000, -1, 16'h12A4, 4'b0000, 1'b0);
        check_frame(16'h12A4, 4'b1101, 4'b0000, -1, 16'h1234, 4'b0000, 1'b0);
        // Digit 2 slot: cnt=3 at cycle 19, so the freeze lands before cnt=4.
        check_frame(16'h1234, 4'b1111, 4'b0000, 19, 16'h1234, 4'b0000, 1'b0);

        // Mid-slot reset, then the following frame must pick up the new value.
        repeat (12) tick();
        digits = 16'h9876;
        dp_en  = 4'b1000;
        rst_n  = 1'b0;
        tick();
        chk("midreset", outs(), {6'd0, 1'b0, 1'b1, 4'b1111, 4'h0});
        rst_n = 1'b1;
        tick();
        check_frame(16'h9876, 4'b1111, 4'b1000, -1, 16'h9876, 4'b1000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the four-digit seven-segment display. It shares the single BCD-to-segment decoder among four digit positions. Each cycle it presents one BCD nibble on the decoder input and drives the active-low anode lines, so each digit is lit in turn. It adds anti-ghosting dead time, leading-zero blanking and blanking of invalid nibbles. Displayed digits are frame-coherent: input values are captured once per scan frame.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, default 1000: dead-time cycles at the start of each slot, with all anodes off; 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  in  1  system clock. One clock domain; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  scan enable; low freezes the scan and blanks the display.
- digits  in  16  four BCD nibbles. [3:0] is digit 0 (rightmost); [15:12] is digit 3.
- dp_en  in  4  decimal point request per digit, active-high.
- blank_lz  in  1  enable leading-zero blanking.
- bcd_out  out  4  nibble for the segment decoder.
- an  out  4  anode drive, active-low; an[i] lights digit i.
- dp_n  out  1  decimal point drive, active-low.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- **State**
  - slot counter cnt, width $clog2(REFRESH_DIV).
  - digit index idx, 2 bits.
  - shadow registers sh_digits (16 bits) and sh_dp (4 bits).
- **Reset** (rst_n low at an edge):
  - cnt = REFRESH_DIV-1, idx = 3, shadows = 0.
  - Outputs: an = 4'b1111, bcd_out = 0, dp_n = 1, frame_start = 0.
- **Advance** (each edge with enable high): cnt increments. When cnt = REFRESH_DIV-1, it wraps to 0 and idx increments mod 4.
- **Frame load**: on the edge that moves (idx=3, cnt=REFRESH_DIV-1) to (idx=0, cnt=0), sh_digits ← digits and sh_dp ← dp_en.
  - No other edge changes the shadows.
  - Input changes mid-frame are invisible until the next frame.
- **Slot phases**, per digit:
  - GAP while cnt < BLANK_CYCLES: an = 1111.
  - ON while cnt ≥ BLANK_CYCLES: an[idx] = 0 unless the digit is suppressed; all other bits are 1.
- **Suppression** of digit idx (evaluated on the shadow values):
  - Its nibble is > 9.
  - Or blank_lz = 1, idx ≠ 0, and the nibbles of digit idx and every higher digit are all zero.
  - Digit 0 is never zero-blanked, so 0000 displays "0".
- **bcd_out** = sh_digits nibble for idx in both GAP and ON, so the decoder settles during the dead time.
- **dp_n** = ~sh_dp[idx] while an[idx] is low; otherwise 1.
- **enable low**:
  - cnt, idx and the shadows hold.
  - an = 1111, dp_n = 1, frame_start = 0; bcd_out holds.
  - When enable returns, the slot resumes from the held cnt.
- **Reset mid-frame**: the reset values above apply immediately at that edge. The scan restarts with a fresh frame load.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Each output value corresponds to the (cnt, idx, shadow) state holding in the same cycle; outputs are computed from next-state.
- First enabled edge after reset:
  - performs the frame load;
  - enters idx=0, cnt=0;
  - frame_start = 1 in that cycle.
- Frame period: 4·REFRESH_DIV enabled cycles, scan order digit 0, 1, 2, 3.
- Per slot: BLANK_CYCLES cycles off, then REFRESH_DIV − BLANK_CYCLES cycles lit.
- frame_start is high only in cycles where idx = 0, cnt = 0 and the enabled edge into that state has occurred. It is exactly one cycle wide per frame.
- Latency from a change on digits to display: up to one frame plus one slot.

## Test plan
All scenarios use REFRESH_DIV = 8 and BLANK_CYCLES = 2.
- **Reset**: hold rst_n low 3 cycles → an = 1111, bcd_out = 0, dp_n = 1, frame_start = 0. On the first enabled edge after release → frame_start = 1, bcd_out = digits[3:0].
- **Basic scan**: digits = 16'h1234, blank_lz = 0, dp_en = 4'b0010.
  - Per slot: 2 cycles of an = 1111, then 6 cycles lit.
  - Slot sequence: an = 1110 / bcd 4; an = 1101 / bcd 3 with dp_n = 0; an = 1011 / bcd 2; an = 0111 / bcd 1.
  - frame_start repeats every 32 cycles.
- **Leading-zero blanking**: blank_lz = 1.
  - digits = 16'h0045 → digits 3 and 2 keep an = 1111; digit 1 shows 4, digit 0 shows 5.
  - digits = 16'h0000 → only digit 0 lights, with bcd 0.
  - digits = 16'h0405 → digit 2 lights with bcd 4 and digit 1 lights with bcd 0 (no zero blanking below a non-zero digit).
- **Invalid nibble**: digits = 16'h12A4 → an[1] never low during digit 1's slot, bcd_out = A there; the other digits are normal.
- **Frame coherence**: change digits from 16'h1234 to 16'h5678 at cycle 10 of a frame → the rest of that frame still shows 1234; the next frame shows 5678.
- **Enable and mid-frame reset**:
  - Drop enable for 5 cycles at cnt = 4 of digit 2's slot → an = 1111 and the counters freeze. After enable returns, digit 2 is lit for the remaining 4 cycles (6 lit cycles in total).
  - Assert rst_n low mid-slot → reset values at that edge; the next frame reloads the shadows.
